// File: rtl/imm_gen_pipe_if.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe_if
// Bundles the two valid/ready channels of imm_gen_pipe.
//   Input channel : in_valid_i, in_ready_o, sel_i[3:0], instr_i[31:0], tag_i
//   Output channel: out_valid_o, out_ready_i, imm_o[XLEN-1:0], tag_o, err_o
// Modports:
//   master : the surrounding pipeline (drives instructions, consumes results)
//   slave  : the imm_gen_pipe block itself
// Parameters: XLEN (immediate width), TAG_W (sideband tag width).
// -----------------------------------------------------------------------------
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [3:0]       sel_i;
    logic [31:0]      instr_i;
    logic [TAG_W-1:0] tag_i;

    logic             out_valid_o;
    logic             out_ready_i;
    logic [XLEN-1:0]  imm_o;
    logic [TAG_W-1:0] tag_o;
    logic             err_o;

    modport master (
        output in_valid_i, sel_i, instr_i, tag_i, out_ready_i,
        input  in_ready_o, out_valid_o, imm_o, tag_o, err_o
    );

    modport slave (
        input  in_valid_i, sel_i, instr_i, tag_i, out_ready_i,
        output in_ready_o, out_valid_o, imm_o, tag_o, err_o
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
// Decodes the RV immediate (I/S/B/J/U, shift amount, CSR zimm) of an incoming
// instruction and queues {imm, tag, err} in a DEPTH-entry FIFO so decode and
// execute can stall independently.
//
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-low reset (0 = reset)
//   flush_i  - synchronous flush, empties the FIFO, blocks that cycle's push
//   bus      - imm_gen_pipe_if.slave: input and output valid/ready channels
//   count_o  - FIFO occupancy, 0..DEPTH
//
// Build option: define IMM_GEN_PIPE_CHECK_EN to store an error flag for
// reserved selects (8..15) and to check XLEN/DEPTH legality. Without it err_o
// is tied to 0; reserved selects still decode to 0.
// -----------------------------------------------------------------------------
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int TAG_W = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    imm_gen_pipe_if.slave          bus,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // ---------------------------------------------------------------- decode
    logic [XLEN-1:0] imm_dec;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_shamt;
    logic            sign_bit;
    logic            unused_opcode;

    assign sign_bit      = bus.instr_i[31];
    // The opcode field never contributes to an immediate.
    assign unused_opcode = ^bus.instr_i[6:0];

    // U-type upper-half extension and the shift-amount width both depend on XLEN.
    if (XLEN == 64) begin : g_x64
        assign imm_u     = {{(XLEN-32){sign_bit}}, bus.instr_i[31:12], 12'b0};
        assign imm_shamt = {{(XLEN-6){1'b0}}, bus.instr_i[25:20]};
    end else begin : g_x32
        assign imm_u     = {bus.instr_i[31:12], 12'b0};
        assign imm_shamt = {{(XLEN-5){1'b0}}, bus.instr_i[24:20]};
    end

    always_comb begin
        imm_dec = '0;
        case (bus.sel_i)
            4'd1: imm_dec = {{(XLEN-12){sign_bit}}, bus.instr_i[31:20]};
            4'd2: imm_dec = {{(XLEN-12){sign_bit}}, bus.instr_i[31:25], bus.instr_i[11:7]};
            4'd3: imm_dec = {{(XLEN-13){sign_bit}}, bus.instr_i[31], bus.instr_i[7],
                             bus.instr_i[30:25], bus.instr_i[11:8], 1'b0};
            4'd4: imm_dec = {{(XLEN-21){sign_bit}}, bus.instr_i[31], bus.instr_i[19:12],
                             bus.instr_i[20], bus.instr_i[30:21], 1'b0};
            4'd5: imm_dec = imm_u;
            4'd6: imm_dec = imm_shamt;
            4'd7: imm_dec = {{(XLEN-5){1'b0}}, bus.instr_i[19:15]};
            default: imm_dec = '0;  // NONE and reserved selects
        endcase
    end

    // ------------------------------------------------------------ FIFO control
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);
    // Readiness ignores out_ready_i on purpose: no combinational path from
    // the consumer back to the producer.
    assign push  = bus.in_valid_i && !full && !flush_i;
    assign pop   = !empty && bus.out_ready_i;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush_i) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) wr_ptr_next = wr_ptr_reg + 1'b1;  // wraps at DEPTH (power of two)
            if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // ---------------------------------------------------------------- storage
    // Contents need no reset; the head is masked to 0 whenever the FIFO is empty.
    logic [XLEN-1:0]  imm_mem [DEPTH];
    logic [TAG_W-1:0] tag_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (push) begin
            imm_mem[wr_ptr_reg] <= imm_dec;
            tag_mem[wr_ptr_reg] <= bus.tag_i;
        end
    end

    assign bus.in_ready_o  = !full;
    assign bus.out_valid_o = !empty;
    assign bus.imm_o       = empty ? '0 : imm_mem[rd_ptr_reg];
    assign bus.tag_o       = empty ? '0 : tag_mem[rd_ptr_reg];
    assign count_o         = count_reg;

`ifdef IMM_GEN_PIPE_CHECK_EN
    localparam bit PARAMS_OK = ((XLEN == 32) || (XLEN == 64)) && (DEPTH >= 2) &&
                               ((DEPTH & (DEPTH - 1)) == 0);

    logic err_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (push) err_mem[wr_ptr_reg] <= bus.sel_i[3];  // 8..15 are reserved
    end

    assign bus.err_o = !empty && err_mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        assert (PARAMS_OK)
            else $error("imm_gen_pipe: XLEN must be 32/64 and DEPTH a power of two >= 2");
    end
`else
    assign bus.err_o = 1'b0;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_gen_pipe
// Drives an XLEN=32 and an XLEN=64 instance with identical stimulus and checks
// both against a queue-based reference model whose immediates are computed
// arithmetically from the instruction fields. Directed vectors first, then
// randomized traffic with random backpressure and flushes, then an
// asynchronous reset in the middle of a stream.
// -----------------------------------------------------------------------------
module tb_imm_gen_pipe;
    localparam int DEPTH = 2;
    localparam int TAG_W = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    logic [$clog2(DEPTH):0] count32;
    logic [$clog2(DEPTH):0] count64;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(TAG_W)) bus32 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(TAG_W)) bus64 ();

    imm_gen_pipe #(.XLEN(32), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut32 (
        .clk(clk), .rst(rst), .flush_i(flush), .bus(bus32), .count_o(count32)
    );
    imm_gen_pipe #(.XLEN(64), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut64 (
        .clk(clk), .rst(rst), .flush_i(flush), .bus(bus64), .count_o(count64)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]       sel;
        logic [31:0]      instr;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t q[$];
    int errors = 0;
    int checks = 0;

    task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    // Reference immediate: assemble the signed offset with arithmetic.
    function automatic logic [63:0] model_imm(input logic [3:0] s, input logic [31:0] w,
                                              input int xlen);
        longint raw;
        longint neg;
        logic [63:0] r;
        neg = w[31] ? 64'sd1 : 64'sd0;
        case (s)
            4'd1: raw = longint'(w[31:20]) - neg * 4096;
            4'd2: raw = (longint'(w[31:25]) << 5) + longint'(w[11:7]) - neg * 4096;
            4'd3: raw = (longint'(w[11:8]) << 1) + (longint'(w[30:25]) << 5)
                        + (longint'(w[7]) << 11) + (longint'(w[31]) << 12) - neg * 8192;
            4'd4: raw = (longint'(w[30:21]) << 1) + (longint'(w[20]) << 11)
                        + (longint'(w[19:12]) << 12) + (longint'(w[31]) << 20)
                        - neg * (longint'(1) << 21);
            4'd5: raw = (longint'(w[31:12]) << 12) - neg * (longint'(1) << 32);
            4'd6: raw = (xlen == 64) ? longint'(w[25:20]) : longint'(w[24:20]);
            4'd7: raw = longint'(w[19:15]);
            default: raw = 0;
        endcase
        r = 64'(raw);
        if (xlen == 32) r[63:32] = '0;
        return r;
    endfunction

    function automatic logic model_err(input logic [3:0] s);
`ifdef IMM_GEN_PIPE_CHECK_EN
        return s >= 4'd8;
`else
        return (s != s);  // always 0 without the error store
`endif
    endfunction

    task automatic check_outputs();
        bit e;
        e = (q.size() == 0);
        check_val("count32", 64'(count32), 64'(q.size()));
        check_val("count64", 64'(count64), 64'(q.size()));
        check_val("out_valid32", 64'(bus32.out_valid_o), 64'(!e));
        check_val("out_valid64", 64'(bus64.out_valid_o), 64'(!e));
        check_val("in_ready32", 64'(bus32.in_ready_o), 64'(q.size() != DEPTH));
        check_val("in_ready64", 64'(bus64.in_ready_o), 64'(q.size() != DEPTH));
        check_val("imm32", 64'(bus32.imm_o), e ? 64'd0 : model_imm(q[0].sel, q[0].instr, 32));
        check_val("imm64", bus64.imm_o, e ? 64'd0 : model_imm(q[0].sel, q[0].instr, 64));
        check_val("tag32", 64'(bus32.tag_o), e ? 64'd0 : 64'(q[0].tag));
        check_val("tag64", 64'(bus64.tag_o), e ? 64'd0 : 64'(q[0].tag));
        check_val("err32", 64'(bus32.err_o), e ? 64'd0 : 64'(model_err(q[0].sel)));
        check_val("err64", 64'(bus64.err_o), e ? 64'd0 : 64'(model_err(q[0].sel)));
    endtask

    task automatic drive(input bit v, input logic [3:0] s, input logic [31:0] ins,
                         input logic [TAG_W-1:0] t, input bit ordy, input bit fl);
        bus32.in_valid_i = v;  bus64.in_valid_i = v;
        bus32.sel_i = s;       bus64.sel_i = s;
        bus32.instr_i = ins;   bus64.instr_i = ins;
        bus32.tag_i = t;       bus64.tag_i = t;
        bus32.out_ready_i = ordy;
        bus64.out_ready_i = ordy;
        flush = fl;
    endtask

    // Called at a falling edge: check, apply inputs, advance model, move to the next falling edge.
    task automatic step(input bit v, input logic [3:0] s, input logic [31:0] ins,
                        input logic [TAG_W-1:0] t, input bit ordy, input bit fl);
        bit do_pop;
        bit do_push;
        entry_t ent;
        check_outputs();
        drive(v, s, ins, t, ordy, fl);
        do_pop  = (q.size() > 0) && ordy;
        do_push = v && (q.size() < DEPTH) && !fl;
        if (fl) begin
            q.delete();
            $display("flush");
        end else begin
            if (do_pop) begin
                $display("pop  tag=%0d sel=%0d instr=%h imm64=%h", q[0].tag, q[0].sel,
                         q[0].instr, model_imm(q[0].sel, q[0].instr, 64));
                void'(q.pop_front());
            end
            if (do_push) begin
                ent.sel = s;
                ent.instr = ins;
                ent.tag = t;
                q.push_back(ent);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        drive(1'b0, 4'd0, 32'd0, '0, 1'b0, 1'b0);

        // Reset state
        @(negedge clk);
        check_outputs();
        rst = 1'b1;
        @(negedge clk);

        // I-type, 1-cycle latency
        step(1'b1, 4'd1, 32'hFFF00093, 5'd3, 1'b1, 1'b0);
        check_val("i_valid", 64'(bus32.out_valid_o), 64'd1);
        check_val("i_imm", 64'(bus32.imm_o), 64'h0000_0000_FFFF_FFFF);
        check_val("i_tag", 64'(bus32.tag_o), 64'd3);

        // S then B back-to-back, then J, U, U(64-bit sign)
        step(1'b1, 4'd2, 32'hFE112E23, 5'd4, 1'b1, 1'b0);
        check_val("s_imm", 64'(bus32.imm_o), 64'h0000_0000_FFFF_FFFC);
        step(1'b1, 4'd3, 32'hFE000CE3, 5'd5, 1'b1, 1'b0);
        check_val("b_imm", 64'(bus32.imm_o), 64'h0000_0000_FFFF_FFF8);
        check_val("b_tag", 64'(bus32.tag_o), 64'd5);
        step(1'b1, 4'd4, 32'h0010006F, 5'd6, 1'b1, 1'b0);
        check_val("j_imm", 64'(bus32.imm_o), 64'h0000_0000_0000_0800);
        step(1'b1, 4'd5, 32'h123452B7, 5'd7, 1'b1, 1'b0);
        check_val("u_imm", 64'(bus32.imm_o), 64'h0000_0000_1234_5000);
        step(1'b1, 4'd5, 32'h800000B7, 5'd8, 1'b1, 1'b0);
        check_val("u64_imm", bus64.imm_o, 64'hFFFF_FFFF_8000_0000);
        check_val("u32_imm", 64'(bus32.imm_o), 64'h0000_0000_8000_0000);
        step(1'b0, 4'd0, 32'd0, 5'd0, 1'b1, 1'b0);

        // Backpressure: three pushes with out_ready low
        step(1'b1, 4'd1, 32'h00100093, 5'd10, 1'b0, 1'b0);
        step(1'b1, 4'd1, 32'h00200093, 5'd11, 1'b0, 1'b0);
        check_val("bp_in_ready", 64'(bus32.in_ready_o), 64'd0);
        check_val("bp_count", 64'(count32), 64'd2);
        step(1'b1, 4'd1, 32'h00300093, 5'd12, 1'b0, 1'b0);
        check_val("bp_head_tag", 64'(bus32.tag_o), 64'd10);
        check_val("bp_head_imm", 64'(bus32.imm_o), 64'd1);
        step(1'b0, 4'd0, 32'd0, 5'd0, 1'b1, 1'b0);
        check_val("bp_drain_tag", 64'(bus32.tag_o), 64'd11);
        step(1'b0, 4'd0, 32'd0, 5'd0, 1'b1, 1'b0);
        check_val("bp_ready_back", 64'(bus32.in_ready_o), 64'd1);

        // Reserved select
        step(1'b1, 4'd9, 32'hFFFFFFFF, 5'd7, 1'b0, 1'b0);
        check_val("rsv_imm", 64'(bus32.imm_o), 64'd0);
`ifdef IMM_GEN_PIPE_CHECK_EN
        check_val("rsv_err", 64'(bus32.err_o), 64'd1);
`else
        check_val("rsv_err", 64'(bus32.err_o), 64'd0);
`endif
        step(1'b0, 4'd0, 32'd0, 5'd0, 1'b1, 1'b0);

        // Flush wins over a simultaneous push
        step(1'b1, 4'd7, 32'h000FD073, 5'd20, 1'b0, 1'b0);
        step(1'b1, 4'd6, 32'h03F0D093, 5'd21, 1'b0, 1'b0);
        check_val("fl_count_before", 64'(count32), 64'd2);
        step(1'b1, 4'd1, 32'h7FF00093, 5'd22, 1'b1, 1'b1);
        check_val("fl_count", 64'(count32), 64'd0);
        check_val("fl_valid", 64'(bus32.out_valid_o), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), $urandom,
                 TAG_W'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 24) == 0);
        end

        // Asynchronous reset in the middle of a stream
        step(1'b1, 4'd1, 32'h80000093, 5'd30, 1'b0, 1'b0);
        step(1'b1, 4'd2, 32'h00A12223, 5'd31, 1'b0, 1'b0);
        check_val("ar_count_before", 64'(count32), 64'd2);
        #2;
        rst = 1'b0;
        #1;
        q.delete();
        check_val("ar_count", 64'(count32), 64'd0);
        check_val("ar_valid", 64'(bus32.out_valid_o), 64'd0);
        check_val("ar_in_ready", 64'(bus32.in_ready_o), 64'd1);
        check_val("ar_imm64", bus64.imm_o, 64'd0);
        check_val("ar_tag", 64'(bus32.tag_o), 64'd0);
        drive(1'b0, 4'd0, 32'd0, '0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        step(1'b1, 4'd4, 32'h8000006F, 5'd1, 1'b1, 1'b0);
        step(1'b0, 4'd0, 32'd0, 5'd0, 1'b1, 1'b0);
        check_outputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
